// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU-side request/response signals and the memory-side bus
// signals handled by mem_port_arbiter. The arbiter connects through the
// master modport (it masters the memory bus). The CPU and memory side
// connects through the slave modport.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();
  // instruction fetch requester
  logic            if_req;
  logic [AW-1:0]   if_addr;
  logic [DW-1:0]   if_rdata;
  logic            if_done;
  logic            if_stall;
  // data access requester
  logic            mem_req;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW/8-1:0] mem_be;
  logic [DW-1:0]   mem_rdata;
  logic            mem_done;
  logic            mem_stall;
  // shared memory bus
  logic            bus_req;
  logic            bus_we;
  logic [AW-1:0]   bus_addr;
  logic [DW-1:0]   bus_wdata;
  logic [DW/8-1:0] bus_be;
  logic            bus_ack;
  logic [DW-1:0]   bus_rdata;
  logic            bus_err;

  modport master (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_ack, bus_rdata,
    output if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );

  modport slave (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_ack, bus_rdata,
    input  if_rdata, if_done, if_stall, mem_rdata, mem_done, mem_stall,
           bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch (IF,
// read-only) and data access (MEM, read/write). MEM has priority. A
// per-transaction timeout aborts an access that never sees bus_ack.
// Optional macro ARB_STARVE_GUARD_EN: after MAX_STARVE consecutive MEM
// grants with IF waiting, the next grant goes to IF.
//
// state    | meaning
// IDLE     | no owner, evaluating requests
// BUSY_IF  | fetch owns the bus, waiting for ack or timeout
// BUSY_MEM | data access owns the bus, waiting for ack or timeout
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int TIMEOUT    = 16,
  parameter int MAX_STARVE = 4
) (
  input  logic                clk,
  input  logic                rstn,
  mem_port_arbiter_if.master  bus_if
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  if (TIMEOUT < 2 || MAX_STARVE < 1) begin : g_param_check
    $error("mem_port_arbiter: TIMEOUT must be >= 2 and MAX_STARVE >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM} state_e;

  state_e          state_q;
  logic [TW-1:0]   tmo_q;
  logic            bus_req_q;
  logic            bus_we_q;
  logic [AW-1:0]   bus_addr_q;
  logic [DW-1:0]   bus_wdata_q;
  logic [DW/8-1:0] bus_be_q;

  logic busy;
  logic tmo_last;
  logic finish;
  logic mem_wins;

  assign busy     = (state_q != IDLE);
  assign tmo_last = (tmo_q == TMO_LAST);
  // An ack on the final timeout cycle counts as a normal completion.
  assign finish   = busy && (bus_if.bus_ack || tmo_last);

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(MAX_STARVE + 1);
  logic [SW-1:0] starve_q;
  logic          starve_full;

  assign starve_full = (starve_q >= SW'(MAX_STARVE));
  assign mem_wins    = bus_if.mem_req && !(bus_if.if_req && starve_full);
`else
  assign mem_wins    = bus_if.mem_req;
`endif

  // Completion, read data and stall decode for the current owner.
  assign bus_if.if_done   = (state_q == BUSY_IF) && finish;
  assign bus_if.mem_done  = (state_q == BUSY_MEM) && finish;
  assign bus_if.if_rdata  = ((state_q == BUSY_IF) && bus_if.bus_ack) ? bus_if.bus_rdata : '0;
  assign bus_if.mem_rdata = ((state_q == BUSY_MEM) && bus_if.bus_ack && !bus_we_q) ?
                            bus_if.bus_rdata : '0;
  assign bus_if.if_stall  = bus_if.if_req && !bus_if.if_done;
  assign bus_if.mem_stall = bus_if.mem_req && !bus_if.mem_done;
  assign bus_if.bus_err   = busy && tmo_last && !bus_if.bus_ack;

  assign bus_if.bus_req   = bus_req_q;
  assign bus_if.bus_we    = bus_we_q;
  assign bus_if.bus_addr  = bus_addr_q;
  assign bus_if.bus_wdata = bus_wdata_q;
  assign bus_if.bus_be    = bus_be_q;

  // Grant FSM: latch winner onto the bus in IDLE, release on ack or timeout.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      tmo_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_be_q    <= '0;
`ifdef ARB_STARVE_GUARD_EN
      starve_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          tmo_q <= '0;
          if (mem_wins) begin
            state_q     <= BUSY_MEM;
            bus_req_q   <= 1'b1;
            bus_we_q    <= bus_if.mem_we;
            bus_addr_q  <= bus_if.mem_addr;
            bus_wdata_q <= bus_if.mem_wdata;
            bus_be_q    <= bus_if.mem_be;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= bus_if.if_req ? starve_q + 1'b1 : '0;
`endif
          end else if (bus_if.if_req) begin
            state_q     <= BUSY_IF;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= bus_if.if_addr;
            bus_wdata_q <= '0;
            bus_be_q    <= '1;
`ifdef ARB_STARVE_GUARD_EN
            starve_q    <= '0;
`endif
          end
        end
        default: begin
          if (finish) begin
            state_q   <= IDLE;
            bus_req_q <= 1'b0;
            tmo_q     <= '0;
          end else begin
            tmo_q     <= tmo_q + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default TIMEOUT=16, MAX_STARVE=4).
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// 1 time unit later, well away from the next edge.
module tb_mem_port_arbiter;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus_if ();

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(16), .MAX_STARVE(4)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_if (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    bus_if.if_req    = 1'b0;
    bus_if.if_addr   = '0;
    bus_if.mem_req   = 1'b0;
    bus_if.mem_we    = 1'b0;
    bus_if.mem_addr  = '0;
    bus_if.mem_wdata = '0;
    bus_if.mem_be    = '0;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
  endtask

  initial begin
    logic       bad;
    int         grants;
    logic [5:0] exp_if_grant;
    logic [5:0] got_if_grant;

    idle_inputs();
    #2;
    check("rst_bus_req",  bus_if.bus_req,  0);
    check("rst_bus_addr", bus_if.bus_addr, 0);
    check("rst_bus_err",  bus_if.bus_err,  0);
    #10 rstn = 1'b1;

    // IF fetch, ack two cycles after bus_req rises
    next_cycle();
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h20;
    settle();
    check("if_stall_c0", bus_if.if_stall, 1);
    check("if_busreq_c0", bus_if.bus_req, 0);
    next_cycle(); settle();
    check("if_busreq_c1", bus_if.bus_req, 1);
    check("if_addr_c1", bus_if.bus_addr, 32'h20);
    check("if_we_c1", bus_if.bus_we, 0);
    check("if_be_c1", bus_if.bus_be, 4'hF);
    check("if_stall_c1", bus_if.if_stall, 1);
    next_cycle(); settle();
    check("if_stall_c2", bus_if.if_stall, 1);
    check("if_done_c2", bus_if.if_done, 0);
    next_cycle();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h12345678;
    settle();
    check("if_done_c3", bus_if.if_done, 1);
    check("if_rdata_c3", bus_if.if_rdata, 32'h12345678);
    check("if_stall_c3", bus_if.if_stall, 0);
    check("if_memdone_c3", bus_if.mem_done, 0);
    check("if_err_c3", bus_if.bus_err, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("if_busreq_c4", bus_if.bus_req, 0);

    // MEM write acked in first bus cycle
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b1; bus_if.mem_addr = 32'h100;
    bus_if.mem_wdata = 32'hDEADBEEF; bus_if.mem_be = 4'hF;
    next_cycle(); settle();
    check("wr_busreq", bus_if.bus_req, 1);
    check("wr_we", bus_if.bus_we, 1);
    check("wr_addr", bus_if.bus_addr, 32'h100);
    check("wr_wdata", bus_if.bus_wdata, 32'hDEADBEEF);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hA5A5A5A5;
    settle();
    check("wr_done", bus_if.mem_done, 1);
    check("wr_rdata", bus_if.mem_rdata, 0);
    check("wr_stall", bus_if.mem_stall, 0);
    check("wr_if_rdata", bus_if.if_rdata, 0);
    next_cycle();
    idle_inputs();
    settle();
    check("wr_busreq_after", bus_if.bus_req, 0);

    // Simultaneous requests: MEM first, IF after one IDLE cycle
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h40;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h200;
    next_cycle(); settle();
    check("both_addr_mem", bus_if.bus_addr, 32'h200);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h11;
    settle();
    check("both_mem_done", bus_if.mem_done, 1);
    check("both_mem_rdata", bus_if.mem_rdata, 32'h11);
    check("both_if_done_0", bus_if.if_done, 0);
    check("both_if_stall", bus_if.if_stall, 1);
    next_cycle();
    bus_if.mem_req = 1'b0; bus_if.bus_ack = 1'b0;
    settle();
    check("both_idle_busreq", bus_if.bus_req, 0);
    check("both_idle_ifdone", bus_if.if_done, 0);
    next_cycle(); settle();
    check("both_addr_if", bus_if.bus_addr, 32'h40);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h22;
    settle();
    check("both_if_done", bus_if.if_done, 1);
    check("both_if_rdata", bus_if.if_rdata, 32'h22);
    check("both_mem_done_0", bus_if.mem_done, 0);
    next_cycle();
    idle_inputs();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h33;
    settle();
    check("idle_ack_ifdone", bus_if.if_done, 0);
    check("idle_ack_memdone", bus_if.mem_done, 0);
    next_cycle();
    bus_if.bus_ack = 1'b0;
    settle();
    check("idle_ack_busreq", bus_if.bus_req, 0);

    // Timeout with no ack: done and bus_err on the 16th cycle after grant
    bus_if.mem_req = 1'b1; bus_if.mem_addr = 32'h300;
    bus_if.bus_rdata = 32'hBAD0BAD0;
    bad = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      next_cycle(); settle();
      if (bus_if.mem_done || bus_if.bus_err || !bus_if.bus_req) bad = 1'b1;
    end
    check("tmo_early_done", bad, 0);
    next_cycle(); settle();
    check("tmo_done", bus_if.mem_done, 1);
    check("tmo_err", bus_if.bus_err, 1);
    check("tmo_rdata", bus_if.mem_rdata, 0);
    next_cycle();
    bus_if.mem_req = 1'b0;
    settle();
    check("tmo_busreq_after", bus_if.bus_req, 0);
    check("tmo_err_after", bus_if.bus_err, 0);

    // Ack on the timeout cycle wins
    bus_if.mem_req = 1'b1; bus_if.mem_addr = 32'h304;
    for (int k = 1; k <= 15; k++) next_cycle();
    next_cycle();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h77;
    settle();
    check("tmo_ack_done", bus_if.mem_done, 1);
    check("tmo_ack_err", bus_if.bus_err, 0);
    check("tmo_ack_rdata", bus_if.mem_rdata, 32'h77);
    next_cycle();
    idle_inputs();

    // Reset in the middle of an IF transaction
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h80;
    next_cycle(); settle();
    check("rstmid_busreq", bus_if.bus_req, 1);
    rstn = 1'b0;
    settle();
    check("rstmid_async_drop", bus_if.bus_req, 0);
    next_cycle();
    rstn = 1'b1;
    settle();
    check("rstmid_idle", bus_if.bus_req, 0);
    next_cycle(); settle();
    check("rstmid_regrant", bus_if.bus_req, 1);
    check("rstmid_addr", bus_if.bus_addr, 32'h80);
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h99;
    settle();
    check("rstmid_done", bus_if.if_done, 1);
    check("rstmid_rdata", bus_if.if_rdata, 32'h99);
    next_cycle();
    idle_inputs();

    // Both requests held: grant order over six grants (1 = IF)
`ifdef ARB_STARVE_GUARD_EN
    exp_if_grant = 6'b010000;
`else
    exp_if_grant = 6'b000000;
`endif
    got_if_grant = '0;
    grants = 0;
    bus_if.if_req = 1'b1; bus_if.if_addr = 32'h500;
    bus_if.mem_req = 1'b1; bus_if.mem_we = 1'b0; bus_if.mem_addr = 32'h400;
    for (int c = 0; c < 30 && grants < 6; c++) begin
      next_cycle();
      bus_if.bus_ack = 1'b0;
      settle();
      if (bus_if.bus_req) begin
        got_if_grant[grants] = (bus_if.bus_addr == 32'h500);
        bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h1;
        grants++;
      end
    end
    check("prio_grant_count", 64'(grants), 6);
    check("prio_grant_order", got_if_grant, exp_if_grant);
    next_cycle();
    idle_inputs();
    next_cycle(); settle();
    check("final_busreq", bus_if.bus_req, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory bus between two pipeline requesters: instruction fetch (IF, read-only) and data access (MEM, read/write).
- Sits between the pipelined CPU core and the memory inside the top-level computer.
- Generates per-requester stall signals so the pipeline freezes while its access is pending.
- Includes a bus timeout so a missing acknowledge cannot hang the CPU.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 16, bus cycles without bus_ack before abort (>=2)
- MAX_STARVE, 4, consecutive MEM grants tolerated while IF waits (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rstn  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  AW  fetch address
- if_rdata  out  DW  fetched word; valid only while if_done=1
- if_done  out  1  fetch completes this cycle
- if_stall  out  1  if_req & ~if_done
- mem_req  in  1  data request; held until mem_done
- mem_we  in  1  1=write, 0=read
- mem_addr  in  AW  data address
- mem_wdata  in  DW  write data
- mem_be  in  DW/8  byte enables
- mem_rdata  out  DW  read data; valid only while mem_done=1
- mem_done  out  1  data access completes this cycle
- mem_stall  out  1  mem_req & ~mem_done
- bus_req  out  1  memory request, registered
- bus_we  out  1  registered write flag
- bus_addr  out  AW  registered address
- bus_wdata  out  DW  registered write data
- bus_be  out  DW/8  registered byte enables
- bus_ack  in  1  memory accepts/completes the access this cycle
- bus_rdata  in  DW  read data, valid with bus_ack
- bus_err  out  1  one-cycle pulse on timeout abort, coincident with the owner's done

Behaviour:
- Reset (async, rstn=0): state IDLE; bus_req, bus_we, bus_addr, bus_wdata, bus_be, bus_err, timeout counter, starve counter all 0. bus_req drops immediately, with no wait for clk.
- FSM states:
  - IDLE: evaluate requests each cycle.
  - BUSY_IF: IF owns the bus.
  - BUSY_MEM: MEM owns the bus.
- IDLE grant:
  - mem_req=1 -> BUSY_MEM; MEM has priority because it is the older instruction.
  - else if_req=1 -> BUSY_IF.
  - On grant, bus_* fields are latched from the winner and bus_req=1 from the next cycle. For IF: bus_we=0, bus_be=all ones, bus_wdata=0.
- BUSY_x:
  - bus_* held stable.
  - The cycle bus_ack=1: x_done=1 combinationally, x_rdata=bus_rdata (reads; 0 for writes).
  - Next edge: bus_req=0, state IDLE.
- Latency: req seen in IDLE at cycle 0 -> bus_req at cycle 1 -> done in the bus_ack cycle. Minimum 2 cycles (ack in cycle 1). Back-to-back grants are separated by one IDLE cycle.
- Requester contract:
  - Advances on the edge ending its done cycle, so IDLE samples only fresh requests and no double issue occurs.
  - If req drops mid-transaction, the transaction still completes and done still pulses.
- Non-owner done is always 0, and non-owner rdata is 0.
- Timeout:
  - Counter clears on grant and increments each BUSY cycle without ack.
  - When it equals TIMEOUT-1 with no ack: owner done=1, rdata=0, bus_err=1 that cycle; next edge -> IDLE with bus_req=0.
  - bus_ack in the same cycle as the timeout wins: normal completion, bus_err=0.
- Simultaneous if_req & mem_req in IDLE: MEM is granted; IF stays stalled and is granted at the next IDLE with no MEM request.
- bus_ack while IDLE is ignored.

Optional Feature:
- Macro ARB_STARVE_GUARD_EN.
- Defined:
  - starve counter increments on each MEM grant issued while if_req=1.
  - Clears on any IF grant, or on a MEM grant with if_req=0.
  - When the counter reaches MAX_STARVE, the next IDLE grant goes to IF even if mem_req=1.
- Undefined: strict MEM priority; counter logic absent.

Test Plan:
- if_req, if_addr=0x00000020; memory acks 2 cycles after bus_req -> bus_addr=0x20, bus_we=0; if_done one cycle with if_rdata=bus_rdata; if_stall high 3 cycles.
- mem_req write, addr=0x100, wdata=0xDEADBEEF, be=0xF, ack in first bus_req cycle -> bus_we=1, bus_wdata=0xDEADBEEF, mem_done in that cycle; mem_rdata=0.
- if_req and mem_req both high at cycle 0 -> mem granted first, if_done after MEM done + 1 IDLE cycle; no overlap of done pulses.
- No bus_ack, TIMEOUT=16 -> mem_done and bus_err pulse together 16 cycles after grant, bus_req low next cycle, mem_rdata=0.
- rstn low mid BUSY_IF -> bus_req=0 immediately; after release, if_req still held -> re-granted and completes normally.
- With ARB_STARVE_GUARD_EN, MAX_STARVE=4, mem_req and if_req held continuously -> grant order M,M,M,M,I,M,...; without macro, IF never granted while mem_req stays high.
